// File: rtl/niveles_pkg.sv
`default_nettype none
// ============================================================================
// Module      : niveles_pkg
// Description : Shared scheduler state encodings and food-level helpers.
// Revision    : 1.0
// ============================================================================
package niveles_pkg;

    typedef enum logic [1:0] {
        PLANIF_NORMAL = 2'b00,
        PLANIF_FEED   = 2'b01,
        PLANIF_TEST   = 2'b10
    } planif_t;

    localparam int                   NIVEL_W   = 2;
    localparam logic [NIVEL_W-1:0]   NIVEL_MAX = 2'd3;

    // Counter width that can hold values 0..n-1, never narrower than one bit.
    function automatic int ancho_cnt(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [NIVEL_W-1:0] nivel_dec_sat(input logic [NIVEL_W-1:0] n);
        return (n == '0) ? '0 : n - 2'd1;
    endfunction

    function automatic logic [NIVEL_W-1:0] nivel_inc_sat(input logic [NIVEL_W-1:0] n);
        return (n == NIVEL_MAX) ? NIVEL_MAX : n + 2'd1;
    endfunction

    function automatic logic [NIVEL_W-1:0] nivel_dec_wrap(input logic [NIVEL_W-1:0] n);
        return (n == '0) ? NIVEL_MAX : n - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_niveles_divisor_tick.sv
`default_nettype none
// ============================================================================
// Module      : divisor_tick
// Description : Prescaler with enable, synchronous clear, half-rate enable and
//               terminal-count input; flags the cycle on which it wraps.
// Revision    : 1.0
// ============================================================================
module divisor_tick #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             half,
    input  logic [CNT_W-1:0] tc,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_step;

    // In half-rate mode the count only advances on every second enabled cycle.
    assign w_step = en && (!half || r_phase);
    assign wrap   = w_step && (r_cnt == tc);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (en) begin
            r_phase <= half ? ~r_phase : 1'b0;
            if (w_step) begin
                r_cnt <= wrap ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/controlador_niveles.sv
`default_nettype none
// ============================================================================
// Module      : controlador_niveles
// Description : Food-level scheduler: timed decay, refill while eating, and
//               manual stepping in test mode. Option macro: NOCHE_LENTA_EN.
// Revision    : 1.0
// ============================================================================
module controlador_niveles
    import niveles_pkg::*;
#(
    parameter int DECAY_CYCLES = 50000000,
    parameter int FEED_CYCLES  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Comiendo,
    input  logic       Senal_MTest,
    input  logic       Paso_Test,
    input  logic       Sensor_Luz,
    output logic [1:0] Nivel_Comida,
    output logic       Tick_Decay,
    output logic       Lleno,
    output logic [1:0] Estado_Planif
);

    localparam int c_max_ciclos = (DECAY_CYCLES > FEED_CYCLES) ? DECAY_CYCLES : FEED_CYCLES;
`ifdef NOCHE_LENTA_EN
    localparam int c_cnt_w = ancho_cnt(2 * c_max_ciclos);
`else
    localparam int c_cnt_w = ancho_cnt(c_max_ciclos);
`endif
    localparam logic [c_cnt_w-1:0] c_tc_decay = c_cnt_w'(DECAY_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tc_feed  = c_cnt_w'(FEED_CYCLES - 1);

    planif_t              r_estado;
    planif_t              w_estado_sig;
    logic [NIVEL_W-1:0]   r_nivel;
    logic [NIVEL_W-1:0]   w_nivel_sig;
    logic                 r_tick;
    logic                 w_tick_sig;
    logic                 r_lleno;
    logic                 w_lleno_sig;
    logic                 w_cambio;
    logic                 w_en;
    logic                 w_clr;
    logic                 w_half;
    logic                 w_wrap;
    logic [c_cnt_w-1:0]   w_tc;

    // Next-state selection: test mode dominates, leaving test always lands in NORMAL.
    always_comb begin
        w_estado_sig = r_estado;
        if (Senal_MTest) begin
            w_estado_sig = PLANIF_TEST;
        end else if (r_estado == PLANIF_TEST) begin
            w_estado_sig = PLANIF_NORMAL;
        end else if (Comiendo) begin
            w_estado_sig = PLANIF_FEED;
        end else begin
            w_estado_sig = PLANIF_NORMAL;
        end
        w_cambio = (w_estado_sig != r_estado);
    end

    // A state change clears the prescaler and suppresses any level update that cycle.
    assign w_en  = !w_cambio && (r_estado != PLANIF_TEST);
    assign w_clr = w_cambio || (r_estado == PLANIF_TEST);
    assign w_tc  = (r_estado == PLANIF_FEED) ? c_tc_feed : c_tc_decay;

`ifdef NOCHE_LENTA_EN
    assign w_half = (r_estado == PLANIF_NORMAL) && !Sensor_Luz;
`else
    logic unused_luz;
    assign unused_luz = Sensor_Luz;
    assign w_half     = 1'b0;
`endif

    divisor_tick #(
        .CNT_W (c_cnt_w)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .half  (w_half),
        .tc    (w_tc),
        .wrap  (w_wrap)
    );

    always_comb begin
        w_nivel_sig = r_nivel;
        w_tick_sig  = 1'b0;
        w_lleno_sig = 1'b0;
        if (!w_cambio) begin
            unique case (r_estado)
                PLANIF_NORMAL: begin
                    if (w_wrap && (r_nivel != '0)) begin
                        w_nivel_sig = nivel_dec_sat(r_nivel);
                        w_tick_sig  = 1'b1;
                    end
                end
                PLANIF_FEED: begin
                    if (w_wrap) begin
                        w_nivel_sig = nivel_inc_sat(r_nivel);
                        w_lleno_sig = (nivel_inc_sat(r_nivel) == NIVEL_MAX);
                    end
                end
                PLANIF_TEST: begin
                    if (Paso_Test) begin
                        w_nivel_sig = nivel_dec_wrap(r_nivel);
                    end
                end
                default: begin
                    w_nivel_sig = r_nivel;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= PLANIF_NORMAL;
            r_nivel  <= NIVEL_MAX;
            r_tick   <= 1'b0;
            r_lleno  <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_nivel  <= w_nivel_sig;
            r_tick   <= w_tick_sig;
            r_lleno  <= w_lleno_sig;
        end
    end

    assign Nivel_Comida  = r_nivel;
    assign Tick_Decay    = r_tick;
    assign Lleno         = r_lleno;
    assign Estado_Planif = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controlador_niveles.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_niveles
// Description : Directed and random checks of controlador_niveles against a
//               cycle-level behavioural model. Honours NOCHE_LENTA_EN.
// Revision    : 1.0
// ============================================================================
module tb_controlador_niveles;

    localparam int DECAY = 8;
    localparam int FEED  = 4;
`ifdef NOCHE_LENTA_EN
    localparam bit NOCHE = 1'b1;
`else
    localparam bit NOCHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Comiendo = 1'b0;
    logic       Senal_MTest = 1'b0;
    logic       Paso_Test = 1'b0;
    logic       Sensor_Luz = 1'b1;
    logic [1:0] Nivel_Comida;
    logic       Tick_Decay;
    logic       Lleno;
    logic [1:0] Estado_Planif;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 NORMAL, 1 FEED, 2 TEST; m_cnt = edges since last event.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_lvl  = 3;
    bit m_tick = 1'b0;
    bit m_full = 1'b0;

    int ticks;
    int fulls;
    int exp_edge;
    bit rc = 1'b0;
    bit rt = 1'b0;
    bit rl = 1'b1;

    controlador_niveles #(
        .DECAY_CYCLES (DECAY),
        .FEED_CYCLES  (FEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Comiendo      (Comiendo),
        .Senal_MTest   (Senal_MTest),
        .Paso_Test     (Paso_Test),
        .Sensor_Luz    (Sensor_Luz),
        .Nivel_Comida  (Nivel_Comida),
        .Tick_Decay    (Tick_Decay),
        .Lleno         (Lleno),
        .Estado_Planif (Estado_Planif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit c, input bit t, input bit p, input bit l);
        int want;
        int period;
        m_tick = 1'b0;
        m_full = 1'b0;
        if (r) begin
            m_mode = 0;
            m_cnt  = 0;
            m_lvl  = 3;
            return;
        end
        want = t ? 2 : ((m_mode == 2) ? 0 : (c ? 1 : 0));
        if (want != m_mode) begin
            m_mode = want;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            period = (NOCHE && !l) ? 2 * DECAY : DECAY;
            m_cnt++;
            if (m_cnt == period) begin
                m_cnt = 0;
                if (m_lvl > 0) begin
                    m_lvl--;
                    m_tick = 1'b1;
                end
            end
        end else if (m_mode == 1) begin
            m_cnt++;
            if (m_cnt == FEED) begin
                m_cnt  = 0;
                m_lvl  = (m_lvl == 3) ? 3 : m_lvl + 1;
                m_full = (m_lvl == 3);
            end
        end else if (p) begin
            m_lvl = (m_lvl + 3) % 4;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit t, input bit p, input bit l);
        reset       = r;
        Comiendo    = c;
        Senal_MTest = t;
        Paso_Test   = p;
        Sensor_Luz  = l;
        @(posedge clk);
        model(r, c, t, p, l);
        #1;
        chk("nivel",  4'(Nivel_Comida),  4'(m_lvl));
        chk("estado", 4'(Estado_Planif), 4'(m_mode));
        chk("tick",   4'(Tick_Decay),    4'(m_tick));
        chk("lleno",  4'(Lleno),         4'(m_full));
    endtask

    initial begin
        // Reset values
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("rst_nivel",  4'(Nivel_Comida),  4'd3);
        chk("rst_estado", 4'(Estado_Planif), 4'd0);
        chk("rst_tick",   4'(Tick_Decay),    4'd0);
        chk("rst_lleno",  4'(Lleno),         4'd0);

        // Idle decay 3->2->1->0, then hold at 0
        ticks = 0;
        for (int i = 1; i <= 32; i++) begin
            step(0, 0, 0, 0, 1);
            ticks += int'(Tick_Decay);
            if (i % 8 == 0) chk("decay_nivel", 4'(Nivel_Comida), 4'((i == 32) ? 0 : 3 - i / 8));
        end
        chk("decay_ticks", 4'(ticks), 4'd3);

        // Feeding from level 0
        step(0, 1, 0, 0, 1);
        chk("feed_estado", 4'(Estado_Planif), 4'd1);
        fulls = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0, 1);
            fulls += int'(Lleno);
            if (i % 4 == 0 && i <= 12) chk("feed_nivel", 4'(Nivel_Comida), 4'(i / 4));
            if (i == 12 || i == 16) chk("feed_lleno", 4'(Lleno), 4'd1);
        end
        chk("lleno_count", 4'(fulls), 4'd2);

        // Test mode: entry step ignored, then 3->2->1->0->3
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 1);
        chk("test_entry_nivel",  4'(Nivel_Comida),  4'd3);
        chk("test_entry_estado", 4'(Estado_Planif), 4'd2);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 1, 1);
            chk("test_paso", 4'(Nivel_Comida), 4'((6 - k) % 4));
            step(0, 0, 1, 0, 1);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("test_exit_estado", 4'(Estado_Planif), 4'd0);
        chk("test_exit_nivel",  4'(Nivel_Comida),  4'd3);

        // Comiendo rising on the same edge as a decay wrap at level 2
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        chk("race_nivel",  4'(Nivel_Comida),  4'd2);
        chk("race_estado", 4'(Estado_Planif), 4'd1);

        // Reset in the middle of a feed count at level 1
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        chk("midrst_nivel",  4'(Nivel_Comida),  4'd3);
        chk("midrst_estado", 4'(Estado_Planif), 4'd0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, 1);
            if (i == 7) chk("postrst_hold", 4'(Nivel_Comida), 4'd3);
            if (i == 8) chk("postrst_dec",  4'(Nivel_Comida), 4'd2);
        end

        // Darkness: slowed decay only when the night option is built in
        exp_edge = NOCHE ? 2 * DECAY : DECAY;
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 2 * DECAY; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == exp_edge - 1) chk("dark_hold", 4'(Nivel_Comida), 4'd3);
            if (i == exp_edge)     chk("dark_dec",  4'(Nivel_Comida), 4'd2);
        end
        step(1, 0, 0, 0, 1);
        for (int i = 1; i <= DECAY; i++) begin
            step(0, 0, 0, 0, 1);
            if (i == DECAY) chk("light_dec", 4'(Nivel_Comida), 4'd2);
        end

        // Random traffic against the model (light held constant when night option is built)
        rc = 1'b0;
        rt = 1'b0;
        rl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 16 == 0) rc = ~rc;
            if ($urandom % 40 == 0) rt = ~rt;
            if (!NOCHE && ($urandom % 8 == 0)) rl = ~rl;
            step($urandom % 250 == 0, rc, rt, $urandom % 3 == 0, rl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
